// File: rtl/aes_rkey_sequencer.sv
// Streams a stored AES key schedule to the cipher rounds, one round key per
// valid/ready handshake, in ascending (encrypt) or descending (decrypt) order.
module aes_rkey_sequencer #(
    parameter int KEY_W  = 128,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        aes_mode,
    input  logic              decrypt,
    input  logic              start,
    input  logic              keys_rdy,
    output logic [ADDR_W-1:0] rkey_addr,
    input  logic [KEY_W-1:0]  rkey_in,
    output logic              rk_valid,
    input  logic              rk_ready,
    output logic [KEY_W-1:0]  rk_data,
    output logic [3:0]        rk_round,
    output logic              rk_last,
    output logic              busy,
    output logic              done,
    output logic              abort,
    output logic [1:0]        fsm_state
);

    // Handshake: a key moves on any cycle with rk_valid=1 and rk_ready=1;
    // rk_data/rk_round hold steady while rk_valid=1 and rk_ready=0.
    typedef enum logic [1:0] {IDLE, WAIT_KEYS, LOAD, STREAM} state_t;

    state_t              state, state_d;
    logic [1:0]          mode_q, mode_d;
    logic                dec_q, dec_d;
    logic [3:0]          nr;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                valid_d, done_d, abort_d;
    logic [KEY_W-1:0]    data_d;
    logic [3:0]          round_d;
    logic                xfer;

    // Nr follows the latched mode, so mid-stream mode changes are invisible.
    always_comb begin
        case (mode_q)
            2'b00:   nr = 4'd10;
            2'b01:   nr = 4'd12;
            default: nr = 4'd14;
        endcase
    end

    assign xfer      = rk_valid && rk_ready;
    assign busy      = (state != IDLE);
    assign rk_last   = rk_valid && (rk_round == nr);
    assign fsm_state = state;

    always_comb begin
        state_d   = state;
        mode_d    = mode_q;
        dec_d     = dec_q;
        addr_d    = addr_q;
        valid_d   = rk_valid;
        data_d    = rk_data;
        round_d   = rk_round;
        done_d    = 1'b0;
        abort_d   = abort;
        rkey_addr = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    mode_d  = aes_mode;
                    dec_d   = decrypt;
                    abort_d = 1'b0;
                    state_d = keys_rdy ? LOAD : WAIT_KEYS;
                end
            end
            WAIT_KEYS: begin
                if (keys_rdy) state_d = LOAD;
            end
            LOAD: begin
                rkey_addr = dec_q ? ADDR_W'(nr) : '0;
                if (!keys_rdy) begin
                    valid_d = 1'b0;
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    data_d  = rkey_in;
                    round_d = 4'd0;
                    valid_d = 1'b1;
                    addr_d  = dec_q ? rkey_addr - ADDR_W'(1) : rkey_addr + ADDR_W'(1);
                    state_d = STREAM;
                end
            end
            STREAM: begin
                rkey_addr = addr_q;
                if (!keys_rdy) begin
                    valid_d = 1'b0;
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else if (xfer) begin
                    if (rk_round == nr) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        data_d  = rkey_in;
                        round_d = rk_round + 4'd1;
                        // Stop stepping once the final key is captured so the address stays in 0..Nr.
                        if (round_d != nr)
                            addr_d = dec_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q   <= 2'b00;
            dec_q    <= 1'b0;
            addr_q   <= '0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_round <= 4'd0;
            done     <= 1'b0;
            abort    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            dec_q    <= dec_d;
            addr_q   <= addr_d;
            rk_valid <= valid_d;
            rk_data  <= data_d;
            rk_round <= round_d;
            done     <= done_d;
            abort    <= abort_d;
        end
    end

endmodule

// File: tb/tb_aes_rkey_sequencer.sv
// Bench for aes_rkey_sequencer: a key-store array feeds the DUT, a schedule model
// fills an expected queue, and a negedge monitor pops it on every handshake.
module tb_aes_rkey_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   aes_mode;
    logic         decrypt;
    logic         start;
    logic         keys_rdy;
    logic [3:0]   rkey_addr;
    logic [127:0] rkey_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         rk_last;
    logic         busy;
    logic         done;
    logic         abort;
    logic [1:0]   fsm_state;

    logic [127:0] ks [0:15];
    logic [132:0] exp_q [$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int xfer_count = 0;
    int done_due = -1;

    logic         prev_hold = 1'b0;
    logic [127:0] prev_data;
    logic [3:0]   prev_round;

    aes_rkey_sequencer #(.KEY_W(128), .ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .aes_mode(aes_mode), .decrypt(decrypt),
        .start(start), .keys_rdy(keys_rdy), .rkey_addr(rkey_addr), .rkey_in(rkey_in),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .rk_round(rk_round),
        .rk_last(rk_last), .busy(busy), .done(done), .abort(abort), .fsm_state(fsm_state)
    );

    // clock / combinational key store
    always #5 clk = ~clk;
    assign rkey_in = ks[rkey_addr];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        cyc++;
        if (prev_hold)
            check(rk_valid && rk_data == prev_data && rk_round == prev_round, "hold_stable",
                  {rk_valid, rk_round, rk_data}, {1'b1, prev_round, prev_data});
        prev_hold  = reset && keys_rdy && rk_valid && !rk_ready;
        prev_data  = rk_data;
        prev_round = rk_round;
        if (done || cyc == done_due)
            check(done && cyc == done_due, "done_pulse", {done, 32'(cyc)}, {1'b1, 32'(done_due)});
        if (reset && keys_rdy && rk_valid && rk_ready) begin
            xfer_count++;
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_xfer", {rk_last, rk_round, rk_data}, 0);
            end else begin
                logic [132:0] e;
                e = exp_q.pop_front();
                check({rk_last, rk_round, rk_data} == e, "xfer", {rk_last, rk_round, rk_data}, e);
                if (e[132]) done_due = cyc + 1;
            end
        end
    end

    // reference model: Nr+1 keys, round r read from address r (encrypt) or Nr-r (decrypt)
    function automatic int nr_of(input logic [1:0] mode);
        return (mode == 2'b00) ? 10 : (mode == 2'b01) ? 12 : 14;
    endfunction

    task automatic push_sched(input logic [1:0] mode, input logic dec, input int upto);
        int nr = nr_of(mode);
        for (int r = 0; r <= nr && r < upto; r++) begin
            int a = dec ? nr - r : r;
            exp_q.push_back({(r == nr), 4'(r), ks[a]});
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check(rk_valid == 0 && done == 0 && abort == 0 && busy == 0, {tag, "_flags"},
              {rk_valid, done, abort, busy}, 0);
        check(rk_round == 0 && rkey_addr == 0, {tag, "_round_addr"}, {rk_round, rkey_addr}, 0);
        check(rk_data == 0, {tag, "_data"}, rk_data, 0);
        check(fsm_state == 0, {tag, "_state"}, fsm_state, 0);
    endtask

    task automatic pulse_start(input logic [1:0] mode, input logic dec);
        aes_mode = mode;
        decrypt  = dec;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        aes_mode = 2'($urandom_range(0, 3));
        decrypt  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input bit rnd);
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            start = 1'b0;
            if (done) begin
                seen = 1;
                break;
            end
            if (i == 1) check(rk_valid == 1, "latency", rk_valid, 1);
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            aes_mode = 2'($urandom_range(0, 3));
            decrypt  = 1'($urandom_range(0, 1));
            tick();
        end
        check(seen, "done_seen", seen, 1);
        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        check(busy == 0, "idle_after_done", busy, 0);
    endtask

    task automatic run_sched(input logic [1:0] mode, input logic dec, input bit rnd);
        push_sched(mode, dec, 99);
        rk_ready = 1'b1;
        pulse_start(mode, dec);
        check(busy == 1 && rk_valid == 0, "load_cycle", {busy, rk_valid}, 2'b10);
        check(abort == 0, "abort_cleared", abort, 0);
        wait_done(rnd);
        tick();
    endtask

    task automatic wait_xfers(input int target, input string name);
        int guard = 0;
        while (xfer_count < target && guard < 100) begin
            tick();
            guard++;
        end
        check(xfer_count == target, name, xfer_count, target);
    endtask

    initial begin
        reset    = 1'b0;
        aes_mode = 2'b00;
        decrypt  = 1'b0;
        start    = 1'b0;
        keys_rdy = 1'b1;
        rk_ready = 1'b1;
        ks[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        ks[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        ks[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        ks[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        ks[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        ks[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        ks[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        ks[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        ks[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        ks[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        ks[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        for (int i = 11; i < 16; i++) ks[i] = {$urandom, $urandom, $urandom, $urandom};
        tick();
        tick();
        check_reset_state("reset");
        reset = 1'b1;
        tick();

        // FIPS-197 schedule, both directions
        run_sched(2'b00, 1'b0, 0);
        run_sched(2'b00, 1'b1, 0);

        // random key store, AES-256 with random back-pressure, then mixed runs
        for (int i = 0; i < 16; i++) ks[i] = {$urandom, $urandom, $urandom, $urandom};
        run_sched(2'b10, 1'b0, 1);
        for (int k = 0; k < 6; k++)
            run_sched(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1);

        // start while key store not ready
        keys_rdy = 1'b0;
        push_sched(2'b01, 1'b0, 99);
        pulse_start(2'b01, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check(busy == 1 && rk_valid == 0, "wait_keys", {busy, rk_valid}, 2'b10);
            tick();
        end
        keys_rdy = 1'b1;
        tick();
        check(busy == 1 && rk_valid == 0, "wait_then_load", {busy, rk_valid}, 2'b10);
        tick();
        check(rk_valid == 1, "wait_first_valid", rk_valid, 1);
        wait_done(0);
        tick();

        // keys_rdy drops after three transfers
        push_sched(2'b01, 1'b1, 3);
        rk_ready = 1'b1;
        pulse_start(2'b01, 1'b1);
        wait_xfers(xfer_count + 3, "abort_pre_xfers");
        keys_rdy = 1'b0;
        tick();
        check(rk_valid == 0 && abort == 1 && busy == 0, "abort_entry",
              {rk_valid, abort, busy}, 3'b010);
        keys_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check(abort == 1 && rk_valid == 0, "abort_sticky", {abort, rk_valid}, 2'b10);
        end
        check(exp_q.size() == 0, "abort_queue", exp_q.size(), 0);
        run_sched(2'b00, 1'b0, 1);

        // reset in the middle of a stream
        push_sched(2'b00, 1'b0, 5);
        rk_ready = 1'b1;
        pulse_start(2'b00, 1'b0);
        wait_xfers(xfer_count + 5, "pre_reset_xfers");
        check(rk_round == 5, "round_before_reset", rk_round, 5);
        reset = 1'b0;
        tick();
        check_reset_state("mid_reset");
        reset = 1'b1;
        tick();
        check(done == 0, "no_done_after_reset", done, 0);
        run_sched(2'b00, 1'b0, 0);

        check(exp_q.size() == 0, "final_queue", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_rkey_sequencer.md
AES_RKEY_SEQUENCER -- requirements
Module: aes_rkey_sequencer

Interface
REQ-001 Parameter KEY_W, default 128, round-key width in bits.
REQ-002 Parameter ADDR_W, default 4, key-store address width.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 aes_mode  in  2  key size: 00=128 (Nr=10), 01=192 (Nr=12), 10/11=256 (Nr=14).
REQ-006 decrypt  in  1  0=ascending key order, 1=descending key order.
REQ-007 start  in  1  single-cycle request to stream one key schedule.
REQ-008 keys_rdy  in  1  level from key store; 1 = all round keys valid.
REQ-009 rkey_addr  out  ADDR_W  key-store read address; read data returns combinationally on rkey_in.
REQ-010 rkey_in  in  KEY_W  key-store read data for rkey_addr.
REQ-011 rk_valid  out  1  rk_data/rk_round/rk_last valid.
REQ-012 rk_ready  in  1  consumer accepts the current key.
REQ-013 rk_data  out  KEY_W  round key presented to the cipher rounds.
REQ-014 rk_round  out  4  round index of rk_data, 0..Nr, always counted upward.
REQ-015 rk_last  out  1  high while rk_valid and rk_round==Nr.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse after the final handshake.
REQ-018 abort  out  1  sticky flag: keys_rdy fell mid-stream.

Function
REQ-019 FSM states: IDLE, WAIT_KEYS, LOAD, STREAM.
REQ-020 IDLE: start=1 latches aes_mode, decrypt, and Nr into internal registers; next state is LOAD if keys_rdy=1, else WAIT_KEYS; abort clears.
REQ-021 WAIT_KEYS: stays until keys_rdy=1, then goes to LOAD.
REQ-022 LOAD: one cycle; rkey_addr = 0 (encrypt) or Nr (decrypt); at the edge rk_data<=rkey_in, rk_round<=0, rk_valid<=1; next state STREAM.
REQ-023 Handshake: a transfer occurs on a cycle where rk_valid=1 and rk_ready=1.
REQ-024 STREAM, transfer with rk_round<Nr: capture rkey_in at the next address; rk_round+1; address steps +1 (encrypt) or -1 (decrypt).
REQ-025 STREAM, transfer with rk_round==Nr: rk_valid<=0, done<=1 for one cycle, next state IDLE.
REQ-026 STREAM without a transfer: rk_data, rk_round, rkey_addr, rk_valid hold unchanged.
REQ-027 rkey_addr always equals the address of the key to be captured next; in IDLE/WAIT_KEYS it is 0.
REQ-028 Latency: start sampled at edge T with keys_rdy=1 gives rk_valid=1 in the cycle after edge T+1.
REQ-029 Throughput: with rk_ready held high, one key per cycle; Nr+1 keys total.
REQ-030 start is ignored while busy=1; aes_mode/decrypt changes while busy have no effect.
REQ-031 keys_rdy=0 in STREAM or LOAD: rk_valid<=0, abort<=1, next state IDLE, and no done pulse; a transfer in that same cycle is discarded.
REQ-032 Address arithmetic is ADDR_W-bit unsigned; it never leaves 0..Nr (no wrap), because stepping stops at rk_round==Nr.

Reset
REQ-033 reset=0 at a clock edge forces: state IDLE, rk_valid=0, done=0, abort=0, busy=0, rk_round=0, rkey_addr=0, rk_data=0, latched mode/decrypt=0.
REQ-034 Reset takes priority over every event in the same cycle, including mid-stream; no done pulse results.

Verification
REQ-035 Key-store model loaded with the FIPS-197 key 000102..0f schedule, aes_mode=00, decrypt=0, rk_ready=1, start pulse -> 11 keys; the first is 000102030405060708090a0b0c0d0e0f at rk_round 0 and the last is 13111d7fe3944a17f307a78b4d2b30c5 with rk_last=1; done follows one cycle after.
REQ-036 Same setup with decrypt=1 -> first key 13111d7f..30c5 (addr 10), last key 00010203..0e0f (addr 0); rk_round runs 0..10.
REQ-037 aes_mode=10, rk_ready toggled randomly -> exactly 15 transfers at addresses 0..14 in order; rk_data stays stable while rk_ready=0.
REQ-038 start with keys_rdy=0 for 5 cycles, then 1 -> busy=1 throughout, rk_valid first rises 2 cycles after keys_rdy rises.
REQ-039 keys_rdy dropped after 3 transfers -> rk_valid=0 next cycle, abort=1 and held, no done; the next start clears abort.
REQ-040 reset=0 asserted during STREAM at rk_round 5 -> all outputs at their reset values after the edge; a new start then begins again at rk_round 0.
